// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bus of the scoreboarded register file.
// The master drives write, read-address and mark/flush requests; the slave returns read data and busy state.
interface regfile_sb_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5,
  parameter int DEPTH  = 2**AWIDTH,
  parameter int NREAD  = 2
);
  logic                    we;
  logic [AWIDTH-1:0]       wa;
  logic [DWIDTH-1:0]       wd;
  logic [NREAD*AWIDTH-1:0] ra;
  logic [NREAD*DWIDTH-1:0] rd;
  logic [NREAD-1:0]        rbusy;
  logic                    mark_en;
  logic [AWIDTH-1:0]       mark_addr;
  logic                    flush;
  logic [DEPTH-1:0]        busy_vec;

  modport master (
    output we, wa, wd, ra, mark_en, mark_addr, flush,
    input  rd, rbusy, busy_vec
  );

  modport slave (
    input  we, wa, wd, ra, mark_en, mark_addr, flush,
    output rd, rbusy, busy_vec
  );
endinterface

// File: rtl/regfile_sb.sv
// Flop-based RV32 register file with async read ports, one write port,
// optional hardwired x0 and write bypass, and a busy-bit scoreboard.
module regfile_sb #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 5,
  parameter int DEPTH    = 2**AWIDTH,
  parameter int NREAD    = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic        clk,
  input logic        rst,
  regfile_sb_if.slave bus
);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              rst_hold;
  logic              wr_ok;
  logic              mark_ok;

  function automatic logic addr_ok(input logic [AWIDTH-1:0] a);
    return (int'(a) < DEPTH) && !(ZERO_REG && (a == '0));
  endfunction

  // Stays set through the first edge after reset release so that edge performs no update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_hold <= 1'b1;
    else     rst_hold <= 1'b0;
  end

  assign wr_ok   = bus.we && addr_ok(bus.wa) && !rst_hold;
  assign mark_ok = bus.mark_en && addr_ok(bus.mark_addr) && !rst_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < DEPTH; n++) mem[n] <= '0;
    end else if (wr_ok) begin
      mem[bus.wa] <= bus.wd;
    end
  end

  // Clear-then-set ordering lets a same-cycle mark override the writeback clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (!rst_hold) begin
      if (bus.flush) begin
        busy <= '0;
      end else begin
        if (wr_ok)   busy[bus.wa]        <= 1'b0;
        if (mark_ok) busy[bus.mark_addr] <= 1'b1;
      end
    end
  end

  always_comb begin
    logic [AWIDTH-1:0] a;
    bus.rd    = '0;
    bus.rbusy = '0;
    a         = '0;
    for (int i = 0; i < NREAD; i++) begin
      a = bus.ra[i*AWIDTH +: AWIDTH];
      if (!rst && addr_ok(a)) begin
        if (BYPASS && wr_ok && (bus.wa == a)) begin
          bus.rd[i*DWIDTH +: DWIDTH] = bus.wd;
        end else begin
          bus.rd[i*DWIDTH +: DWIDTH] = mem[a];
          bus.rbusy[i]               = busy[a];
        end
      end
    end
  end

  assign bus.busy_vec = busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb with a queue-based scoreboard.
// Expected outputs come from an associative-array model of registers and pending producers.
module tb_regfile_sb;
  localparam int DWIDTH = 32;
  localparam int AWIDTH = 5;
  localparam int DEPTH  = 24;
  localparam int NREAD  = 3;

  typedef struct {
    bit          we;
    int          wa;
    logic [31:0] wd;
    int          ra [NREAD];
    bit          mark_en;
    int          mark_addr;
    bit          flush;
    bit          rst;
  } op_t;

  typedef struct {
    logic [NREAD*DWIDTH-1:0] rd;
    logic [NREAD-1:0]        rbusy;
    logic [DEPTH-1:0]        busy_vec;
    string                   tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_sb_if #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .DEPTH(DEPTH), .NREAD(NREAD)) bus ();

  regfile_sb #(
    .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .DEPTH(DEPTH), .NREAD(NREAD),
    .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t        expq [$];
  logic [31:0] mmem [int];
  bit          pend [int];
  bit          hold = 1'b1;
  op_t         cur;
  int          npass = 0;
  int          ntotal = 0;

  function automatic op_t idle();
    op_t o;
    o.we = 0; o.wa = 0; o.wd = '0; o.mark_en = 0; o.mark_addr = 0; o.flush = 0; o.rst = 0;
    for (int i = 0; i < NREAD; i++) o.ra[i] = 0;
    return o;
  endfunction

  function automatic bit in_range(int a);
    return (a > 0) && (a < DEPTH);
  endfunction

  function automatic bit write_valid(op_t o);
    return o.we && in_range(o.wa) && !hold && !o.rst;
  endfunction

  function automatic logic [31:0] exp_rd(op_t o, int a);
    if (o.rst || !in_range(a)) return '0;
    if (write_valid(o) && o.wa == a) return o.wd;
    return mmem.exists(a) ? mmem[a] : 32'h0;
  endfunction

  function automatic bit exp_rbusy(op_t o, int a);
    if (o.rst || !in_range(a)) return 1'b0;
    if (write_valid(o) && o.wa == a) return 1'b0;
    return pend.exists(a);
  endfunction

  // Advance the model by the edge that just consumed the previously driven op.
  task automatic model_edge();
    bit wv, mv;
    if (rst) return;
    if (hold) begin
      hold = 1'b0;
      return;
    end
    wv = cur.we && in_range(cur.wa);
    mv = cur.mark_en && in_range(cur.mark_addr);
    if (wv) mmem[cur.wa] = cur.wd;
    if (cur.flush) begin
      pend.delete();
    end else begin
      if (wv) pend.delete(cur.wa);
      if (mv) pend[cur.mark_addr] = 1'b1;
    end
  endtask

  task automatic applyStimulus(input op_t o, input string tag);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    cur = o;
    rst = o.rst;
    if (o.rst) begin
      mmem.delete();
      pend.delete();
      hold = 1'b1;
    end
    bus.we        = o.we;
    bus.wa        = AWIDTH'(o.wa);
    bus.wd        = o.wd;
    bus.mark_en   = o.mark_en;
    bus.mark_addr = AWIDTH'(o.mark_addr);
    bus.flush     = o.flush;
    for (int i = 0; i < NREAD; i++) bus.ra[i*AWIDTH +: AWIDTH] = AWIDTH'(o.ra[i]);
    e.tag = tag;
    e.busy_vec = '0;
    for (int n = 0; n < DEPTH; n++) if (!o.rst && pend.exists(n)) e.busy_vec[n] = 1'b1;
    for (int i = 0; i < NREAD; i++) begin
      e.rd[i*DWIDTH +: DWIDTH] = exp_rd(o, o.ra[i]);
      e.rbusy[i]               = exp_rbusy(o, o.ra[i]);
    end
    expq.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    for (int i = 0; i < NREAD; i++) begin
      ntotal++;
      if (bus.rd[i*DWIDTH +: DWIDTH] === e.rd[i*DWIDTH +: DWIDTH]) npass++;
      else $display("[TB] FAIL %s rd%0d: got %h expected %h", e.tag, i,
                    bus.rd[i*DWIDTH +: DWIDTH], e.rd[i*DWIDTH +: DWIDTH]);
      ntotal++;
      if (bus.rbusy[i] === e.rbusy[i]) npass++;
      else $display("[TB] FAIL %s rbusy%0d: got %b expected %b", e.tag, i, bus.rbusy[i], e.rbusy[i]);
    end
    ntotal++;
    if (bus.busy_vec === e.busy_vec) npass++;
    else $display("[TB] FAIL %s busy_vec: got %h expected %h", e.tag, bus.busy_vec, e.busy_vec);
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) checkOutput(expq.pop_front());
  end

  initial begin
    op_t o;
    cur = idle();
    o = idle();
    bus.we = 0; bus.wa = '0; bus.wd = '0; bus.ra = '0;
    bus.mark_en = 0; bus.mark_addr = '0; bus.flush = 0;

    o.rst = 1; applyStimulus(o, "reset"); applyStimulus(o, "reset");
    o = idle(); o.we = 1; o.wa = 9; o.wd = 32'hBAD0BAD0; o.mark_en = 1; o.mark_addr = 9;
    o.ra[0] = 9; applyStimulus(o, "release_ignored");
    o = idle(); o.ra[0] = 9; applyStimulus(o, "release_after");

    o = idle(); o.we = 1; o.wa = 5; o.wd = 32'hDEADBEEF; applyStimulus(o, "t1_wr5");
    o = idle(); o.ra[0] = 5; applyStimulus(o, "t1_rd5");
    o.rst = 1; o.mark_en = 1; o.mark_addr = 5; applyStimulus(o, "t1_rst");
    o = idle(); o.ra[0] = 5; applyStimulus(o, "t1_release"); applyStimulus(o, "t1_after");

    o = idle(); o.we = 1; o.wa = 0; o.wd = 32'hFFFFFFFF; o.mark_en = 1; o.mark_addr = 0;
    applyStimulus(o, "t2_wr0");
    o = idle(); applyStimulus(o, "t2_rd0");

    o = idle(); o.we = 1; o.wa = 7; o.wd = 32'h11; applyStimulus(o, "t3_wr7");
    o.wd = 32'h22; o.ra[0] = 7; o.ra[1] = 7; o.ra[2] = 7; applyStimulus(o, "t3_bypass");
    o = idle(); o.ra[0] = 7; o.ra[1] = 7; applyStimulus(o, "t3_after");

    o = idle(); o.mark_en = 1; o.mark_addr = 3; o.ra[0] = 3; applyStimulus(o, "t4_mark3");
    o = idle(); o.ra[0] = 3; applyStimulus(o, "t4_busy3");
    o.we = 1; o.wa = 3; o.wd = 32'h55; applyStimulus(o, "t4_wb3");
    o = idle(); o.ra[0] = 3; applyStimulus(o, "t4_clear3");

    o = idle(); o.mark_en = 1; o.mark_addr = 4; o.we = 1; o.wa = 4; o.wd = 32'h9; o.ra[0] = 4;
    applyStimulus(o, "t5_markwr4");
    o = idle(); o.ra[0] = 4; o.ra[1] = 4; applyStimulus(o, "t5_after");

    o = idle(); o.mark_en = 1;
    o.mark_addr = 1;  applyStimulus(o, "t6_m1");
    o.mark_addr = 2;  applyStimulus(o, "t6_m2");
    o.mark_addr = 31; applyStimulus(o, "t6_m31");
    o.mark_addr = 23; applyStimulus(o, "t6_m23");
    o.mark_addr = 6; o.flush = 1; o.ra[0] = 1; o.ra[1] = 2; o.ra[2] = 23;
    applyStimulus(o, "t6_flush");
    o = idle(); o.ra[0] = 6; o.ra[1] = 1; applyStimulus(o, "t6_after");

    o = idle(); o.we = 1; o.wa = 28; o.wd = 32'h1234; o.mark_en = 1; o.mark_addr = 28;
    o.ra[0] = 28; o.ra[1] = 20; o.ra[2] = 31; applyStimulus(o, "t7_oob_wr");
    o = idle(); o.ra[0] = 28; o.ra[1] = 20; applyStimulus(o, "t7_oob_rd");

    for (int c = 0; c < 400; c++) begin
      o = idle();
      o.we        = ($urandom % 2) == 0;
      o.wa        = int'($urandom % 32);
      o.wd        = $urandom;
      o.mark_en   = ($urandom % 3) == 0;
      o.mark_addr = (($urandom % 4) == 0) ? o.wa : int'($urandom % 32);
      o.flush     = ($urandom % 20) == 0;
      o.rst       = ($urandom % 100) == 0;
      for (int i = 0; i < NREAD; i++)
        o.ra[i] = (($urandom % 3) == 0) ? o.wa : int'($urandom % 32);
      applyStimulus(o, "rand");
    end

    o = idle(); applyStimulus(o, "drain");
    for (int k = 0; k < 10 && expq.size() > 0; k++) @(negedge clk);
    ntotal++;
    if (expq.size() == 0) npass++;
    else $display("[TB] FAIL drain: got %0d pending expected 0", expq.size());
    @(posedge clk);
    $display("[TB] %0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
